sk6805_stream_tx: RTL and testbench

Streaming SK6805 serial transmitter: accepts RGB pixels over a valid/ready handshake, buffers them in a small FIFO, and serialises each as a 24-bit GRB word using the SK6805 one-wire pulse-width code, terminated by a latch (reset) gap. It sits directly downstream of the RGB breathing-light/colour task outputs. It is the frame-oriented, back-pressured replacement for per-LED fixed drivers on chained RGB strips (RGB[5:0] pins).

---
 rtl/sk6805_pkg.sv | 32 +++
 rtl/sk6805_pix_fifo.sv | 57 +++++
 rtl/sk6805_stream_tx.sv | 162 ++++++++++++++++
 tb/tb_sk6805_stream_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sk6805_pkg.sv
// Shared types, FSM state encodings and default 10 MHz timing for the SK6805 stream transmitter.
package sk6805_pkg;

  localparam int unsigned DefT0h      = 3;
  localparam int unsigned DefT1h      = 6;
  localparam int unsigned DefTBit     = 12;
  localparam int unsigned DefResetCyc = 800;

  typedef logic [2:0] sk_state_t;

  localparam sk_state_t StIdle  = 3'd0;
  localparam sk_state_t StLoad  = 3'd1;
  localparam sk_state_t StHigh  = 3'd2;
  localparam sk_state_t StLow   = 3'd3;
  localparam sk_state_t StLatch = 3'd4;

  // FIFO entry: frame-last flag followed by the colour in wire order.
  typedef struct packed {
    logic       last;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } sk_pix_t;

  // (c * (bright + 1)) >> 8: bright = 255 is identity, bright = 0 is black.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] bright);
    logic [15:0] prod;
    prod = {8'h00, c} * ({8'h00, bright} + 16'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/sk6805_pix_fifo.sv
// Small synchronous pixel FIFO; push is refused when full, pop is ignored when empty.
module sk6805_pix_fifo
  import sk6805_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  logic    pop_i,
  input  sk_pix_t data_i,
  output sk_pix_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [Aw:0] DepthC = Depth[Aw:0];

  sk_pix_t       mem_q [Depth];
  logic [Aw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [Aw:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == DepthC);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/sk6805_stream_tx.sv
// SK6805 streaming transmitter: FIFO-buffered RGB pixels sent as GRB pulse-width words.
// Define SK6805_BRIGHT_EN to scale every channel by Bright at LOAD.
module sk6805_stream_tx
  import sk6805_pkg::*;
#(
  parameter int unsigned T0H        = DefT0h,
  parameter int unsigned T1H        = DefT1h,
  parameter int unsigned T_BIT      = DefTBit,
  parameter int unsigned RESET_CYC  = DefResetCyc,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_10MHz,
  input  logic       Rst_n,
  input  logic       Pix_Valid,
  output logic       Pix_Ready,
  input  logic [7:0] R_In,
  input  logic [7:0] G_In,
  input  logic [7:0] B_In,
  input  logic       Frame_Last,
  input  logic [7:0] Bright,
  output logic       LED_IO,
  output logic       Busy,
  output logic       Frame_Done,
  output logic       Underrun
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] HiZero   = CntW'(T0H - 1);
  localparam logic [CntW-1:0] HiOne    = CntW'(T1H - 1);
  localparam logic [CntW-1:0] LoZero   = CntW'(T_BIT - T0H - 1);
  localparam logic [CntW-1:0] LoOne    = CntW'(T_BIT - T1H - 1);
  localparam logic [CntW-1:0] LatchCnt = CntW'(RESET_CYC - 1);

  sk_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [23:0]     shift_q, shift_d;
  logic            last_q, last_d;
  logic            led_q, led_d, done_q, done_d, under_q, under_d;
  logic            push, pop, full, empty;
  sk_pix_t         fifo_in, head;
  logic [7:0]      g_s, r_s, b_s;

  assign Pix_Ready  = Rst_n & ~full;
  assign push       = Pix_Valid & Pix_Ready;
  assign fifo_in    = {Frame_Last, G_In, R_In, B_In};
  assign Busy       = (state_q != StIdle) | ~empty;
  assign LED_IO     = led_q;
  assign Frame_Done = done_q;
  assign Underrun   = under_q;

  sk6805_pix_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_10MHz),
    .rst_ni (Rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (fifo_in),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

`ifdef SK6805_BRIGHT_EN
  assign g_s = scale_chan(head.g, Bright);
  assign r_s = scale_chan(head.r, Bright);
  assign b_s = scale_chan(head.b, Bright);
`else
  logic unused_bright;
  assign unused_bright = ^Bright;
  assign g_s = head.g;
  assign r_s = head.r;
  assign b_s = head.b;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: if (!empty || push) state_d = StLoad;
      StLoad: begin
        pop     = 1'b1;
        shift_d = {g_s, r_s, b_s};
        bit_d   = 5'd23;
        last_d  = head.last;
        cnt_d   = g_s[7] ? HiOne : HiZero;
        state_d = StHigh;
      end
      StHigh: begin
        if (cnt_q == '0) begin
          cnt_d   = shift_q[23] ? LoOne : LoZero;
          state_d = StLow;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLow: begin
        cnt_d = cnt_q - 1'b1;
        if (bit_q != 5'd0) begin
          if (cnt_q == '0) begin
            shift_d = shift_q << 1;
            bit_d   = bit_q - 5'd1;
            cnt_d   = shift_q[22] ? HiOne : HiZero;
            state_d = StHigh;
          end
        end else if (last_q) begin
          if (cnt_q == '0) begin
            cnt_d   = LatchCnt;
            state_d = StLatch;
          end
        end else if (!empty && cnt_q <= CntW'(1)) begin
          // LOAD stands in for the final low cycle, so the bit period stays exact.
          state_d = StLoad;
        end else if (cnt_q == '0) begin
          under_d = 1'b1;
          cnt_d   = LatchCnt;
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = (!empty || push) ? StLoad : StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    led_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_10MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      led_q   <= led_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

endmodule

// File: tb/tb_sk6805_stream_tx.sv
// Directed bench for sk6805_stream_tx; sample index k counts negedges after the first push edge.
`timescale 1ns / 1ps
module tb_sk6805_stream_tx;

  typedef struct packed {
    logic       last;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } px_t;

  logic       clk, Rst_n, Pix_Valid, Pix_Ready, Frame_Last;
  logic       LED_IO, Busy, Frame_Done, Underrun;
  logic [7:0] R_In, G_In, B_In, Bright;

  px_t  q_pix[$];
  int   q_at[$];
  logic led_s [3200];
  logic done_s[3200];
  logic und_s [3200];
  logic rdy_s [3200];
  logic busy_s[3200];
  int   n_chk, n_pass;

  sk6805_stream_tx dut (
    .clk_10MHz (clk),
    .Rst_n     (Rst_n),
    .Pix_Valid (Pix_Valid),
    .Pix_Ready (Pix_Ready),
    .R_In      (R_In),
    .G_In      (G_In),
    .B_In      (B_In),
    .Frame_Last(Frame_Last),
    .Bright    (Bright),
    .LED_IO    (LED_IO),
    .Busy      (Busy),
    .Frame_Done(Frame_Done),
    .Underrun  (Underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic offer(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                       input logic last, input int at);
    px_t p;
    p.last = last;
    p.g    = g;
    p.r    = r;
    p.b    = b;
    q_pix.push_back(p);
    q_at.push_back(at);
  endtask

  // Offer queued pixels (each no earlier than its start sample) and record n samples.
  task automatic run(input int n);
    logic acc;
    for (int s = 0; s < n; s++) begin
      if (q_pix.size() > 0 && s >= q_at[0]) begin
        Pix_Valid = 1'b1;
        {Frame_Last, G_In, R_In, B_In} = q_pix[0];
      end else begin
        Pix_Valid = 1'b0;
      end
      acc = Pix_Valid & Pix_Ready;
      @(negedge clk);
      led_s[s]  = LED_IO;
      done_s[s] = Frame_Done;
      und_s[s]  = Underrun;
      rdy_s[s]  = Pix_Ready;
      busy_s[s] = Busy;
      if (acc) begin
        void'(q_pix.pop_front());
        void'(q_at.pop_front());
      end
    end
    Pix_Valid = 1'b0;
  endtask

  // First sample offset within a 288-cycle pixel that deviates from the expected code, or -1.
  function automatic int wave_err(input logic [23:0] w, input int start);
    for (int k = 0; k < 288; k++) begin
      logic b;
      int   hi;
      b  = w[23 - k / 12];
      hi = b ? 6 : 3;
      if (led_s[start + k] !== ((k % 12) < hi)) return k;
    end
    return -1;
  endfunction

  function automatic int count_under(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (und_s[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset;
    Rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (LED_IO !== 1'b0) $display("FAIL rst_led: got %b want 0", LED_IO); else n_pass++;
    n_chk++; if (Pix_Ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", Pix_Ready); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if (Frame_Done !== 1'b0) $display("FAIL rst_done: got %b want 0", Frame_Done);
    else n_pass++;
    n_chk++; if (Underrun !== 1'b0) $display("FAIL rst_under: got %b want 0", Underrun); else n_pass++;
    Rst_n = 1'b1;
    #1;
    n_chk++; if (Pix_Ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", Pix_Ready);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (Busy !== 1'b0) $display("FAIL rst_busy_after: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_single;
    int e, bad;
    q_pix.delete(); q_at.delete();
    offer(8'hFF, 8'h00, 8'h01, 1'b1, 0);
    run(1100);
    n_chk++; if (led_s[0] !== 1'b0) $display("FAIL single_load_led: got %b want 0", led_s[0]);
    else n_pass++;
    n_chk++; if (busy_s[0] !== 1'b1) $display("FAIL single_load_busy: got %b want 1", busy_s[0]);
    else n_pass++;
    e = wave_err(24'hFF0001, 1);
    n_chk++; if (e !== -1) $display("FAIL single_wave: first bad offset %0d want -1", e);
    else n_pass++;
    bad = 0;
    for (int k = 289; k <= 1088; k++) if (led_s[k] !== 1'b0 || done_s[k] !== 1'b0) bad++;
    n_chk++; if (bad !== 0) $display("FAIL single_latch_quiet: got %0d active samples want 0", bad);
    else n_pass++;
    n_chk++; if (done_s[1089] !== 1'b1) $display("FAIL single_done: got %b want 1", done_s[1089]);
    else n_pass++;
    n_chk++; if (busy_s[1089] !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy_s[1089]);
    else n_pass++;
    n_chk++; if (done_s[1090] !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", done_s[1090]);
    else n_pass++;
    n_chk++; if (count_under(1100) !== 0)
      $display("FAIL single_no_under: got %0d want 0", count_under(1100));
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [23:0] w[6];
    int e;
    w[0] = 24'hA5C33C; w[1] = 24'h0F00F0; w[2] = 24'h123456;
    w[3] = 24'hFEDCBA; w[4] = 24'h800001; w[5] = 24'h7E7E7E;
    q_pix.delete(); q_at.delete();
    for (int j = 0; j < 6; j++) offer(w[j][23:16], w[j][15:8], w[j][7:0], j == 5, 0);
    run(2600);
    n_chk++; if (rdy_s[4] !== 1'b0) $display("FAIL b2b_full: got %b want 0", rdy_s[4]); else n_pass++;
    n_chk++; if (rdy_s[288] !== 1'b0) $display("FAIL b2b_full_hold: got %b want 0", rdy_s[288]);
    else n_pass++;
    n_chk++; if (rdy_s[289] !== 1'b1) $display("FAIL b2b_ready_pop: got %b want 1", rdy_s[289]);
    else n_pass++;
    for (int j = 0; j < 6; j++) begin
      e = wave_err(w[j], 1 + 288 * j);
      n_chk++; if (e !== -1) $display("FAIL b2b_wave%0d: first bad offset %0d want -1", j, e);
      else n_pass++;
    end
    n_chk++; if (done_s[2528] !== 1'b0) $display("FAIL b2b_done_early: got %b want 0", done_s[2528]);
    else n_pass++;
    n_chk++; if (done_s[2529] !== 1'b1) $display("FAIL b2b_done: got %b want 1", done_s[2529]);
    else n_pass++;
    n_chk++; if (count_under(2600) !== 0)
      $display("FAIL b2b_no_under: got %0d want 0", count_under(2600));
    else n_pass++;
  endtask

  task automatic test_underrun;
    int e;
    q_pix.delete(); q_at.delete();
    offer(8'hF0, 8'hF0, 8'hF0, 1'b0, 0);
    offer(8'h0F, 8'h0F, 8'h0F, 1'b0, 400);
    run(2250);
    n_chk++; if (und_s[289] !== 1'b1) $display("FAIL under_pulse1: got %b want 1", und_s[289]);
    else n_pass++;
    n_chk++; if (done_s[1089] !== 1'b1) $display("FAIL under_done1: got %b want 1", done_s[1089]);
    else n_pass++;
    n_chk++; if (led_s[1089] !== 1'b0) $display("FAIL under_load_led: got %b want 0", led_s[1089]);
    else n_pass++;
    e = wave_err(24'h0F0F0F, 1090);
    n_chk++; if (e !== -1) $display("FAIL under_wave2: first bad offset %0d want -1", e);
    else n_pass++;
    n_chk++; if (und_s[1378] !== 1'b1) $display("FAIL under_pulse2: got %b want 1", und_s[1378]);
    else n_pass++;
    n_chk++; if (done_s[2178] !== 1'b1) $display("FAIL under_done2: got %b want 1", done_s[2178]);
    else n_pass++;
    n_chk++; if (count_under(2250) !== 2)
      $display("FAIL under_count: got %0d want 2", count_under(2250));
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int e;
    q_pix.delete(); q_at.delete();
    for (int j = 0; j < 4; j++) offer(8'hFF, 8'h00, 8'h00, 1'b0, 0);
    run(64);
    n_chk++; if (led_s[63] !== 1'b1) $display("FAIL mid_high: got %b want 1", led_s[63]); else n_pass++;
    Rst_n = 1'b0;
    #1;
    n_chk++; if (LED_IO !== 1'b0) $display("FAIL mid_led_async: got %b want 0", LED_IO); else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if (Pix_Ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", Pix_Ready);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    Rst_n = 1'b1;
    #1;
    n_chk++; if (Pix_Ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", Pix_Ready);
    else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL mid_fifo_empty: got %b want 0", Busy); else n_pass++;
    q_pix.delete(); q_at.delete();
    offer(8'h12, 8'h34, 8'h56, 1'b1, 0);
    run(1100);
    e = wave_err(24'h123456, 1);
    n_chk++; if (e !== -1) $display("FAIL mid_restart_wave: first bad offset %0d want -1", e);
    else n_pass++;
    n_chk++; if (done_s[1089] !== 1'b1) $display("FAIL mid_restart_done: got %b want 1", done_s[1089]);
    else n_pass++;
  endtask

  task automatic test_frame_last;
    logic [23:0] w[5];
    int e, bad;
    w[0] = 24'h010203; w[1] = 24'hC0FFEE; w[2] = 24'h5A5A5A; w[3] = 24'h00FF00; w[4] = 24'hAAAA55;
    q_pix.delete(); q_at.delete();
    for (int j = 0; j < 5; j++) offer(w[j][23:16], w[j][15:8], w[j][7:0], j == 2 || j == 4, 0);
    run(3100);
    for (int j = 0; j < 3; j++) begin
      e = wave_err(w[j], 1 + 288 * j);
      n_chk++; if (e !== -1) $display("FAIL fl_wave%0d: first bad offset %0d want -1", j, e);
      else n_pass++;
    end
    bad = 0;
    for (int k = 865; k <= 1664; k++) if (led_s[k] !== 1'b0 || done_s[k] !== 1'b0) bad++;
    n_chk++; if (bad !== 0) $display("FAIL fl_latch_quiet: got %0d active samples want 0", bad);
    else n_pass++;
    n_chk++; if (done_s[1665] !== 1'b1) $display("FAIL fl_done1: got %b want 1", done_s[1665]);
    else n_pass++;
    e = wave_err(w[3], 1666);
    n_chk++; if (e !== -1) $display("FAIL fl_wave3: first bad offset %0d want -1", e); else n_pass++;
    e = wave_err(w[4], 1954);
    n_chk++; if (e !== -1) $display("FAIL fl_wave4: first bad offset %0d want -1", e); else n_pass++;
    n_chk++; if (done_s[3042] !== 1'b1) $display("FAIL fl_done2: got %b want 1", done_s[3042]);
    else n_pass++;
    n_chk++; if (count_under(3100) !== 0)
      $display("FAIL fl_no_under: got %0d want 0", count_under(3100));
    else n_pass++;
  endtask

  task automatic test_bright;
    int e;
`ifdef SK6805_BRIGHT_EN
    Bright = 8'h7F;
    q_pix.delete(); q_at.delete();
    offer(8'hFF, 8'hFF, 8'hFF, 1'b1, 0);
    run(1100);
    e = wave_err(24'h7F7F7F, 1);
    n_chk++; if (e !== -1) $display("FAIL bright_7f: first bad offset %0d want -1", e); else n_pass++;
    Bright = 8'h00;
    offer(8'hFF, 8'hFF, 8'hFF, 1'b1, 0);
    run(1100);
    e = wave_err(24'h000000, 1);
    n_chk++; if (e !== -1) $display("FAIL bright_00: first bad offset %0d want -1", e); else n_pass++;
`else
    Bright = 8'h00;
    q_pix.delete(); q_at.delete();
    offer(8'hFF, 8'hFF, 8'hFF, 1'b1, 0);
    run(1100);
    e = wave_err(24'hFFFFFF, 1);
    n_chk++; if (e !== -1) $display("FAIL bright_ignored: first bad offset %0d want -1", e);
    else n_pass++;
`endif
    Bright = 8'hFF;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    Rst_n      = 1'b0;
    Pix_Valid  = 1'b0;
    Frame_Last = 1'b0;
    R_In       = 8'h00;
    G_In       = 8'h00;
    B_In       = 8'h00;
    Bright     = 8'hFF;
    repeat (3) @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_underrun;
    test_reset_mid;
    test_frame_last;
    test_bright;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
